// File: rtl/mem_lsu_if.sv
// Word-wide req/ack data bus between the memory-access stage and the data RAM.
// The LSU is the master and owns every registered request field.
interface mem_lsu_if;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic        ram_ack;
    logic [31:0] ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MIPS memory-access stage: runs loads/stores over a req/ack bus with big-endian
// lane select, store replication and load extension; stalls the pipe while busy.
module mem_lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_wb_stall,
    input  logic [4:0]  i_mem_wd,
    input  logic        i_mem_wreg,
    input  logic [31:0] i_mem_wdata,
    input  logic [7:0]  i_mem_aluop,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_reg,
    output logic [4:0]  o_wb_wd,
    output logic        o_wb_wreg,
    output logic [31:0] o_wb_wdata,
    output logic        o_stallreq,
    output logic        o_exc_adel,
    output logic        o_exc_ades,
    output logic        o_bus_err,
    mem_lsu_if.master   bus
);
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t           r_state, w_next_state;
    logic             r_ram_req, r_ram_we;
    logic [31:0]      r_ram_addr, r_ram_wdata;
    logic [3:0]       r_ram_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hold;
    logic             r_err, r_load;
    logic [7:0]       r_op;
    logic [1:0]       r_lo;

    logic             w_is_mem, w_is_load, w_misaligned;
    logic [3:0]       w_sel;
    logic [31:0]      w_store_data, w_load_data;
    logic [7:0]       w_lane_b;
    logic [15:0]      w_lane_h;
    logic             w_start, w_finish, w_timeout;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_is_mem     = 1'b1;
        w_is_load    = 1'b1;
        w_misaligned = 1'b0;
        w_sel        = 4'b1111;
        w_store_data = i_mem_reg;
        case (i_mem_aluop)
            OP_LB, OP_LBU: w_sel = 4'b1000 >> i_mem_addr[1:0];
            OP_LH, OP_LHU: begin
                w_misaligned = i_mem_addr[0];
                w_sel        = i_mem_addr[1] ? 4'b0011 : 4'b1100;
            end
            OP_LW: w_misaligned = |i_mem_addr[1:0];
            OP_SB: begin
                w_is_load    = 1'b0;
                w_sel        = 4'b1000 >> i_mem_addr[1:0];
                w_store_data = {4{i_mem_reg[7:0]}};
            end
            OP_SH: begin
                w_is_load    = 1'b0;
                w_misaligned = i_mem_addr[0];
                w_sel        = i_mem_addr[1] ? 4'b0011 : 4'b1100;
                w_store_data = {2{i_mem_reg[15:0]}};
            end
            OP_SW: begin
                w_is_load    = 1'b0;
                w_misaligned = |i_mem_addr[1:0];
            end
            default: begin
                w_is_mem  = 1'b0;
                w_is_load = 1'b0;
            end
        endcase
    end

    // Lane 0 (offset 0) sits in bits [31:24], so the byte shift is 8*(3-offset).
    always_comb begin
        w_lane_b = 8'(bus.ram_rdata >> {~r_lo, 3'b000});
        w_lane_h = r_lo[1] ? bus.ram_rdata[15:0] : bus.ram_rdata[31:16];
        case (r_op)
            OP_LB:   w_load_data = {{24{w_lane_b[7]}}, w_lane_b};
            OP_LBU:  w_load_data = {24'd0, w_lane_b};
            OP_LH:   w_load_data = {{16{w_lane_h[15]}}, w_lane_h};
            OP_LHU:  w_load_data = {16'd0, w_lane_h};
            default: w_load_data = bus.ram_rdata;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        w_timeout    = 1'b0;
        o_wb_wd      = i_mem_wd;
        o_wb_wreg    = 1'b0;
        o_wb_wdata   = i_mem_wdata;
        o_stallreq   = 1'b0;
        o_exc_adel   = 1'b0;
        o_exc_ades   = 1'b0;
        o_bus_err    = 1'b0;
        if (rst) begin
            w_next_state = S_IDLE;
            o_wb_wd      = 5'd0;
            o_wb_wdata   = 32'd0;
        end else if (i_flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_is_mem) begin
                        o_wb_wreg = i_mem_wreg;
                    end else if (w_misaligned) begin
                        o_exc_adel = w_is_load;
                        o_exc_ades = !w_is_load;
                    end else begin
                        o_stallreq   = 1'b1;
                        w_start      = 1'b1;
                        w_next_state = S_REQ;
                    end
                end
                S_REQ: begin
                    o_stallreq = 1'b1;
                    if (bus.ram_ack) begin
                        w_finish     = 1'b1;
                        w_next_state = S_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        w_timeout    = 1'b1;
                        w_next_state = S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_err) begin
                        o_bus_err = 1'b1;
                    end else if (r_load) begin
                        o_wb_wreg  = i_mem_wreg;
                        o_wb_wdata = r_hold;
                    end
                    // Holding in DONE keeps the same instruction from being reissued.
                    if (!i_wb_stall) w_next_state = S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= 32'd0;
            r_ram_sel   <= 4'd0;
            r_ram_wdata <= 32'd0;
            r_cnt       <= '0;
            r_hold      <= 32'd0;
            r_err       <= 1'b0;
            r_load      <= 1'b0;
            r_op        <= 8'd0;
            r_lo        <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (i_flush) begin
                r_ram_req <= 1'b0;
                r_cnt     <= '0;
            end else if (w_start) begin
                r_ram_req   <= 1'b1;
                r_ram_we    <= !w_is_load;
                r_ram_addr  <= {i_mem_addr[31:2], 2'b00};
                r_ram_sel   <= w_sel;
                r_ram_wdata <= w_store_data;
                r_cnt       <= '0;
                r_err       <= 1'b0;
                r_load      <= w_is_load;
                r_op        <= i_mem_aluop;
                r_lo        <= i_mem_addr[1:0];
            end else if (w_finish) begin
                r_ram_req <= 1'b0;
                if (r_load) r_hold <= w_load_data;
            end else if (w_timeout) begin
                r_ram_req <= 1'b0;
                r_err     <= 1'b1;
            end else if (r_state == S_REQ) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.ram_req   = r_ram_req;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_sel   = r_ram_sel;
    assign bus.ram_wdata = r_ram_wdata;
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: per-instruction expected traces derived from
// a transaction-level model, compared against the DUT on every negative edge.
module tb_mem_lsu;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        stall, adel, ades, berr, req;
        logic        chk_wd, chk_wdata, chk_berr, chk_bus;
        logic        we;
        logic [31:0] addr, bwdata;
        logic [3:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, wb_stall;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_addr, mem_reg;
    logic [7:0]  mem_aluop;
    logic [4:0]  wb_wd;
    logic        wb_wreg, stallreq, exc_adel, exc_ades, bus_err;
    logic [31:0] wb_wdata;

    int   n_assert = 0;
    int   n_fail = 0;
    int   stall_seen = 0;
    exp_t exp_q[$];

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .i_flush(flush), .i_wb_stall(wb_stall),
        .i_mem_wd(mem_wd), .i_mem_wreg(mem_wreg), .i_mem_wdata(mem_wdata),
        .i_mem_aluop(mem_aluop), .i_mem_addr(mem_addr), .i_mem_reg(mem_reg),
        .o_wb_wd(wb_wd), .o_wb_wreg(wb_wreg), .o_wb_wdata(wb_wdata),
        .o_stallreq(stallreq), .o_exc_adel(exc_adel), .o_exc_ades(exc_ades),
        .o_bus_err(bus_err), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural model: access size, lane mask, store replication, load extraction.
    function automatic int op_size(input logic [7:0] op);
        case (op)
            8'hE0, 8'hE4, 8'hE8: return 1;
            8'hE1, 8'hE5, 8'hE9: return 2;
            8'hE3, 8'hEB:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [7:0] op);
        return op inside {8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5};
    endfunction

    function automatic logic [3:0] model_sel(input int s, input int a);
        int m;
        m = ((1 << s) - 1) << (4 - s - a);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_store(input int s, input logic [31:0] r);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[31 - 8*i -: 8] = r[8*(s - 1 - (i % s)) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input int a, input logic [31:0] rd);
        int s;
        logic [31:0] v;
        s = op_size(op);
        v = 32'd0;
        for (int i = a; i < a + s; i++) v = (v << 8) | ((rd >> (24 - 8*i)) & 32'hFF);
        if ((op == 8'hE0 || op == 8'hE1) && v[8*s - 1]) v = v | ~((32'd1 << (8*s)) - 32'd1);
        return v;
    endfunction

    function automatic exp_t base_exp(input logic [4:0] wd, input logic [31:0] wdata);
        exp_t e;
        e = '{default: '0};
        e.wd = wd;
        e.wdata = wdata;
        e.chk_wd = 1'b1;
        e.chk_wdata = 1'b1;
        e.chk_berr = 1'b1;
        return e;
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        if (stallreq === 1'b1) stall_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_wd)    check("wb_wd", 32'(wb_wd), 32'(e.wd));
            if (e.chk_wdata) check("wb_wdata", wb_wdata, e.wdata);
            check("wb_wreg", 32'(wb_wreg), 32'(e.wreg));
            check("stallreq", 32'(stallreq), 32'(e.stall));
            check("exc_adel", 32'(exc_adel), 32'(e.adel));
            check("exc_ades", 32'(exc_ades), 32'(e.ades));
            if (e.chk_berr)  check("bus_err", 32'(bus_err), 32'(e.berr));
            check("ram_req", 32'(bus.ram_req), 32'(e.req));
            if (e.chk_bus) begin
                check("ram_we", 32'(bus.ram_we), 32'(e.we));
                check("ram_addr", bus.ram_addr, e.addr);
                check("ram_sel", 32'(bus.ram_sel), 32'(e.sel));
                check("ram_wdata", bus.ram_wdata, e.bwdata);
            end
        end
    end

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        exp_t e;
        rst = 1'b1; flush = 1'b0; wb_stall = 1'b0;
        mem_aluop = 8'h20; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234;
        bus.ram_ack = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = base_exp(5'd0, 32'd0);
            e.chk_bus = (i > 0);
            step(e);
        end
        rst = 1'b0;
    endtask

    // ack_at: REQ cycle carrying ram_ack (0 or >TIMEOUT = never); flush_at: REQ cycle with flush.
    task automatic run_instr(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] regv,
                             input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                             input int ack_at, input int flush_at, input int hold,
                             input logic [31:0] rdata);
        int   s, n;
        bit   ld, err;
        exp_t e;
        logic [31:0] res;
        s = op_size(op);
        ld = op_load(op);
        mem_aluop = op; mem_addr = addr; mem_reg = regv;
        mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        flush = 1'b0; wb_stall = 1'b0;
        bus.ram_ack = 1'b0; bus.ram_rdata = $urandom;
        e = base_exp(wd, wdata);
        if (s == 0) begin
            bus.ram_ack = 1'($urandom_range(0, 1));
            e.wreg = wreg;
            step(e);
            return;
        end
        if ((addr % s) != 0) begin
            e.adel = ld;
            e.ades = !ld;
            step(e);
            return;
        end
        e.stall = 1'b1; e.chk_wd = 1'b0; e.chk_wdata = 1'b0;
        step(e);
        err = !(ack_at >= 1 && ack_at <= TIMEOUT);
        n = err ? TIMEOUT : ack_at;
        e.req = 1'b1; e.chk_bus = 1'b1; e.we = !ld;
        e.addr = {addr[31:2], 2'b00};
        e.sel = model_sel(s, int'(addr[1:0]));
        e.bwdata = ld ? 32'd0 : model_store(s, regv);
        if (ld) e.chk_bus = 1'b1;
        for (int k = 1; k <= n; k++) begin
            if (k == flush_at) begin
                flush = 1'b1;
                bus.ram_ack = 1'($urandom_range(0, 1));
                e.stall = 1'b0; e.chk_berr = 1'b0;
                if (ld) begin
                    exp_t f;
                    f = e;
                    f.chk_bus = 1'b0;
                    step(f);
                end else begin
                    step(e);
                end
                flush = 1'b0;
                mem_aluop = 8'h00; mem_wreg = 1'b0;
                bus.ram_ack = 1'b1; bus.ram_rdata = $urandom;
                e = base_exp(wd, wdata);
                step(e);
                bus.ram_ack = 1'b0;
                return;
            end
            bus.ram_ack = (k == ack_at);
            bus.ram_rdata = (k == ack_at) ? rdata : $urandom;
            if (ld) begin
                exp_t f;
                f = e;
                f.chk_bus = 1'b1;
                f.bwdata = bus.ram_wdata;
                f.chk_bus = 1'b0;
                check("load_req_we", 32'(bus.ram_we), 32'd0);
                check("load_req_addr", bus.ram_addr, e.addr);
                check("load_req_sel", 32'(bus.ram_sel), 32'(e.sel));
                step(f);
            end else begin
                step(e);
            end
        end
        res = ld ? model_load(op, int'(addr[1:0]), rdata) : wdata;
        for (int h = 0; h <= hold; h++) begin
            wb_stall = (h < hold);
            bus.ram_ack = 1'($urandom_range(0, 1));
            bus.ram_rdata = $urandom;
            e = base_exp(wd, res);
            e.wreg = (ld && !err) ? wreg : 1'b0;
            e.berr = err;
            e.chk_wdata = !err;
            step(e);
        end
        wb_stall = 1'b0;
        bus.ram_ack = 1'b0;
    endtask

    initial begin : driver
        int s0, s, ack, fl, ri;
        logic [7:0] op;
        logic [31:0] addr;
        rst = 1'b1; flush = 1'b0; wb_stall = 1'b0;
        mem_aluop = 8'h20; mem_wd = 5'd0; mem_wreg = 1'b0;
        mem_wdata = 32'd0; mem_addr = 32'd0; mem_reg = 32'd0;
        bus.ram_ack = 1'b0; bus.ram_rdata = 32'd0;
        @(posedge clk);
        #1;
        reset_cycles(2);

        check("pin_load_lb", model_load(8'hE0, 3, 32'h000000F0), 32'hFFFFFFF0);
        check("pin_load_lhu", model_load(8'hE5, 0, 32'h8001_0000), 32'h0000_8001);
        check("pin_sel_sh", 32'(model_sel(2, 2)), 32'h3);
        check("pin_store_sh", model_store(2, 32'hAAAABEEF), 32'hBEEFBEEF);

        run_instr(8'h20, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 0, 0, 32'h0);
        s0 = stall_seen;
        run_instr(8'hE0, 32'h103, 32'h0, 5'd7, 1'b1, 32'h55, 1, 0, 0, 32'h000000F0);
        check("lb_stall_cycles", 32'(stall_seen - s0), 32'd2);
        run_instr(8'hE4, 32'h103, 32'h0, 5'd7, 1'b1, 32'h55, 1, 0, 0, 32'h000000F0);
        run_instr(8'hE9, 32'h202, 32'hAAAABEEF, 5'd3, 1'b0, 32'h99, 2, 0, 0, 32'h0);
        run_instr(8'hE3, 32'h301, 32'h0, 5'd9, 1'b1, 32'h77, 1, 0, 0, 32'h0);
        run_instr(8'hEB, 32'h302, 32'h0, 5'd9, 1'b0, 32'h77, 1, 0, 0, 32'h0);
        s0 = stall_seen;
        run_instr(8'hE3, 32'h400, 32'h0, 5'd4, 1'b1, 32'h66, 0, 0, 0, 32'h0);
        check("timeout_stall_cycles", 32'(stall_seen - s0), 32'd17);
        run_instr(8'hE3, 32'h404, 32'h0, 5'd4, 1'b1, 32'h66, TIMEOUT, 0, 0, 32'hCAFEF00D);
        run_instr(8'hE3, 32'h408, 32'h0, 5'd6, 1'b1, 32'h11, 5, 2, 0, 32'h0);
        run_instr(8'hE1, 32'h50E, 32'h0, 5'd8, 1'b1, 32'h22, 1, 0, 3, 32'h1234_8765);
        run_instr(8'hE8, 32'h601, 32'h0000_00A5, 5'd1, 1'b0, 32'h0, 3, 0, 1, 32'h0);
        reset_cycles(2);

        for (int t = 0; t < 250; t++) begin
            ri = $urandom_range(0, 10);
            case (ri)
                0: op = 8'hE0; 1: op = 8'hE1; 2: op = 8'hE3; 3: op = 8'hE4;
                4: op = 8'hE5; 5: op = 8'hE8; 6: op = 8'hE9; 7: op = 8'hEB;
                8: op = 8'h20; 9: op = 8'h00;
                default: op = 8'($urandom);
            endcase
            s = op_size(op);
            addr = $urandom;
            if (s > 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(s - 1);
            ack = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 4);
            fl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom,
                      ack, fl, $urandom_range(0, 3), $urandom);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage of the 5-stage MIPS pipeline; sits between the ex_mem pipeline register and the mem_wb register.
- Executes loads and stores over a req/ack data bus, and performs byte-lane select, alignment and sign/zero extension.
- Holds the pipeline through the ctrl stall request while a bus transaction is outstanding.
- Non-memory instructions pass through combinationally.

Parameters:
- TIMEOUT, 16: REQ cycles without ram_ack before the access is aborted with bus error.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous abort of the current instruction
- wb_stall  in  1  mem_wb will not capture this cycle
- mem_wd  in  5  destination register from ex_mem
- mem_wreg  in  1  write enable from ex_mem
- mem_wdata  in  32  ALU result from ex_mem
- mem_aluop  in  8  operation code
- mem_addr  in  32  effective address
- mem_reg  in  32  store data (rt)
- wb_wd  out  5  destination register to mem_wb
- wb_wreg  out  1  write enable to mem_wb
- wb_wdata  out  32  result to mem_wb
- stallreq  out  1  stall request to ctrl
- exc_adel  out  1  load address misaligned
- exc_ades  out  1  store address misaligned
- bus_err  out  1  access timed out
- ram_req  out  1  bus request (registered)
- ram_we  out  1  1 = write (registered)
- ram_addr  out  32  word address, bits [1:0] = 0 (registered)
- ram_sel  out  4  byte enables; bit3 = bits[31:24] (registered)
- ram_wdata  out  32  write data (registered)
- ram_ack  in  1  transaction complete
- ram_rdata  in  32  read data, valid when ram_ack = 1

Behaviour:
- Ops: LB=E0, LH=E1, LW=E3, LBU=E4, LHU=E5, SB=E8, SH=E9, SW=EB (hex). Any other code is a non-memory op.
- Byte order is big-endian: addr[1:0]=0 selects bits[31:24], sel=1000.
  - Halfword: addr[1]=0 selects bits[31:16], sel=1100.
  - Word: sel=1111.
- Store data is replicated to every lane: byte in all 4 lanes, halfword in both halves.
- Load results: LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
- Reset: state=IDLE, ram_req=0, ram_we=0, ram_addr=0, ram_sel=0, ram_wdata=0, counter=0, hold reg=0.
  - Combinational outputs under rst=1: wb_wd=0, wb_wreg=0, wb_wdata=0, stallreq=0, exc_*=0, bus_err=0.
- FSM states are IDLE, REQ, DONE.
- IDLE:
  - Non-memory op: wb_* = mem_*, stallreq=0.
  - Misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0):
    - no bus access; exc_adel (load) or exc_ades (store) =1 that cycle;
    - wb_wreg=0, wb_wd/wb_wdata = mem_wd/mem_wdata, stallreq=0.
  - Aligned memory op: stallreq=1, wb_wreg=0; load bus registers, ram_req<=1, counter<=0; go to REQ.
- REQ:
  - stallreq=1, wb_wreg=0, bus outputs held stable.
  - ram_ack=1: ram_req<=0; for loads, capture the extended data into the hold reg; go to DONE.
  - Else counter increments. When counter reaches TIMEOUT-1 without ack: ram_req<=0, set error flag, go to DONE.
- DONE:
  - stallreq=0, wb_wd=mem_wd.
  - Load OK: wb_wreg=mem_wreg, wb_wdata=hold.
  - Store OK: wb_wreg=0, wb_wdata=mem_wdata.
  - Error: bus_err=1, wb_wreg=0.
  - wb_stall=1 keeps the state in DONE with the same outputs; wb_stall=0 goes to IDLE.
  - This prevents reissuing an access while ex_mem still holds the same instruction.
- flush=1, any state: next state IDLE, ram_req<=0, counter<=0. Same cycle: wb_wreg=0, stallreq=0, exc_*=0.
  - An abandoned bus transaction's late ram_ack arriving in IDLE/DONE is ignored.
- Priority: rst > flush > ram_ack > timeout.
- ram_ack and timeout in the same cycle: the ack wins, no error.
- Latency: aligned load with ack in the first REQ cycle needs 3 cycles (IDLE, REQ, DONE), giving 2 stall cycles. Non-memory ops take 0 extra cycles.

Test Plan:
- ADD pass-through: aluop=0x20, wd=5, wreg=1, wdata=0x1234 -> wb_* equals the inputs the same cycle; stallreq=0; ram_req never asserted.
- LB, addr=0x103, ram_rdata=0x000000F0, ack in 1st REQ cycle -> ram_addr=0x100, sel=0001; DONE wb_wdata=0xFFFFFFF0; stallreq high exactly 2 cycles. Repeat with LBU -> 0x000000F0.
- SH, addr=0x202, mem_reg=0xAAAABEEF -> ram_we=1, sel=0011, ram_wdata=0xBEEFBEEF; wb_wreg=0 throughout.
- LW, addr=0x301 -> exc_adel=1 for 1 cycle, ram_req stays 0, wb_wreg=0, stallreq=0.
- LW, ram_ack held 0 with TIMEOUT=16 -> ram_req drops after 16 REQ cycles; bus_err=1 in DONE; wb_wreg=0. Ack on the 16th cycle -> no error.
- LW in REQ, flush=1 -> next cycle IDLE with ram_req=0; a later ram_ack=1 has no effect. Also: DONE with wb_stall=1 for 3 cycles -> outputs stable, no second ram_req.
